// File: rtl/spad_arb_pkg.sv
// Shared types for the scratchpad port arbiter.
//   arb_state_e : port either free for round-robin or reserved by a burst owner
//   owner_e     : which requester (A = NoC memory manager, B = core/AXI side)
//   rd_tag_t    : read-return tag carried alongside the memory read latency
package spad_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    typedef enum logic {OWN_A, OWN_B} owner_e;

    typedef struct packed {
        logic   vld;
        owner_e own;
    } rd_tag_t;

    localparam int STALL_W = 16;

    function automatic owner_e other_of(input owner_e o);
        return (o == OWN_A) ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/spad_rd_tag_pipe.sv
// Read-return tag delay line: DEPTH stages of rd_tag_t, so the tag leaves the
// pipe in the same cycle the memory presents the matching read data.
//   clk_ctrl          : clock
//   clk_ctrl_rst_low  : asynchronous active-low reset, empties the pipe
//   tag_i             : tag for the beat accepted this cycle
//   tag_o             : tag whose read data is on mem_dout this cycle
module spad_rd_tag_pipe
    import spad_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk_ctrl,
    input  logic    clk_ctrl_rst_low,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t [DEPTH-1:0] stage_q;

    // NOTE: only the tags need reset -- clearing their valid bits is what drops
    // in-flight reads; the memory data path itself is never reset.
    always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
        if (!clk_ctrl_rst_low) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/spad_port_arbiter.sv
// Shares one scratchpad SRAM port between requester A (NoC decoder memory
// manager) and requester B (core/AXI). Round-robin per cycle, optional burst
// lock bounded by MAX_HOLD, read data steered back to its issuer RD_LAT later.
//   clk_ctrl, clk_ctrl_rst_low        : clock, async active-low reset
//   a_/b_valid, lock, addr, wdata, wstrb : request beat (wstrb 1 = write)
//   a_/b_ready                        : same-cycle grant
//   a_/b_rvalid, rdata                : read return, rdata 0 when not valid
//   mem_en, mem_we, mem_addr, mem_din : memory command, mem_dout read data
//   stall_cnt                         : saturating count of stalled request-cycles
module spad_port_arbiter
    import spad_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BW        = 32,
    parameter int OFFSET_SZ = 12,
    parameter int MAX_HOLD  = 16,
    parameter int RD_LAT    = 1
) (
    input  logic               clk_ctrl,
    input  logic               clk_ctrl_rst_low,
    input  logic               a_valid,
    input  logic               a_lock,
    input  logic [ADDR_W-1:0]  a_addr,
    input  logic [BW-1:0]      a_wdata,
    input  logic               a_wstrb,
    output logic               a_ready,
    output logic               a_rvalid,
    output logic [BW-1:0]      a_rdata,
    input  logic               b_valid,
    input  logic               b_lock,
    input  logic [ADDR_W-1:0]  b_addr,
    input  logic [BW-1:0]      b_wdata,
    input  logic               b_wstrb,
    output logic               b_ready,
    output logic               b_rvalid,
    output logic [BW-1:0]      b_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BW-1:0]      mem_din,
    input  logic [BW-1:0]      mem_dout,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    arb_state_e           state_q, state_d;
    owner_e               owner_q, owner_d;
    owner_e               prio_q, prio_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    logic                 grant_a, grant_b, accept, forced;
    logic                 owner_valid, other_valid;
    owner_e               winner;
    logic                 win_lock, win_write;
    logic [OFFSET_SZ-1:0] win_offset;
    logic [BW-1:0]        win_wdata;

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    always_comb begin
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        forced      = 1'b0;
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        hold_d      = hold_q;
        owner_valid = (owner_q == OWN_A) ? a_valid : b_valid;
        other_valid = (owner_q == OWN_A) ? b_valid : a_valid;

        // Grants are combinational, so they are masked explicitly while reset
        // is held to keep every output at 0.
        if (clk_ctrl_rst_low) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (a_valid && (!b_valid || prio_q == OWN_A)) grant_a = 1'b1;
                    else if (b_valid)                             grant_b = 1'b1;
                end
                ARB_LOCKED: begin
                    if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_ONE;
                    // Owner has had its bounded hold; a waiting peer takes over.
                    if (hold_q == HOLD_MAX && other_valid) begin
                        forced  = 1'b1;
                        grant_a = (owner_q == OWN_B);
                        grant_b = (owner_q == OWN_A);
                    end else if (owner_valid) begin
                        grant_a = (owner_q == OWN_A);
                        grant_b = (owner_q == OWN_B);
                    end
                end
                default: ;
            endcase
        end

        winner     = grant_b ? OWN_B : OWN_A;
        win_lock   = grant_b ? b_lock : a_lock;
        win_write  = grant_b ? b_wstrb : a_wstrb;
        win_offset = grant_b ? b_addr[OFFSET_SZ-1:0] : a_addr[OFFSET_SZ-1:0];
        win_wdata  = grant_b ? b_wdata : a_wdata;

        if (grant_a || grant_b) begin
            if (win_lock) begin
                // A locked owner continuing its burst just keeps counting.
                if (state_q == ARB_IDLE || forced) begin
                    state_d = ARB_LOCKED;
                    owner_d = winner;
                    hold_d  = HOLD_ONE;
                end
            end else begin
                state_d = ARB_IDLE;
                hold_d  = '0;
            end
            // Priority passes to the peer after any unlocked beat, and back to
            // the evicted owner after a forced release.
            if (!win_lock || forced) prio_d = other_of(winner);
        end
    end

    assign accept = grant_a | grant_b;

    // Saturating add of up to two stalled requesters per cycle.
    logic [1:0]       stall_inc;
    logic [STALL_W:0] stall_sum;
    assign stall_inc = {1'b0, a_valid && !grant_a} + {1'b0, b_valid && !grant_b};
    assign stall_sum = {1'b0, stall_q} + {{(STALL_W - 1){1'b0}}, stall_inc};
    assign stall_d   = stall_sum[STALL_W] ? '1 : stall_sum[STALL_W-1:0];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its peers.
    always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
        if (!clk_ctrl_rst_low) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_A;
            prio_q  <= OWN_A;
            hold_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            hold_q  <= hold_d;
            stall_q <= stall_d;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign mem_en    = accept;
    assign mem_we    = accept && win_write;
    assign mem_addr  = accept ? {{(ADDR_W - OFFSET_SZ){1'b0}}, win_offset} : '0;
    assign mem_din   = accept ? win_wdata : '0;
    assign stall_cnt = stall_q;

    // Upper address bits are deliberately discarded by the offset mask.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{a_addr[ADDR_W-1:OFFSET_SZ], b_addr[ADDR_W-1:OFFSET_SZ]};

    rd_tag_t tag_in, tag_out;
    assign tag_in = '{vld: accept && !win_write, own: winner};

    spad_rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
        .clk_ctrl         (clk_ctrl),
        .clk_ctrl_rst_low (clk_ctrl_rst_low),
        .tag_i            (tag_in),
        .tag_o            (tag_out)
    );

    assign a_rvalid = tag_out.vld && (tag_out.own == OWN_A);
    assign b_rvalid = tag_out.vld && (tag_out.own == OWN_B);
    assign a_rdata  = a_rvalid ? mem_dout : '0;
    assign b_rdata  = b_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_spad_port_arbiter.sv
// Self-checking bench for spad_port_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a rule-level model with a
// simple SRAM behind the port.
module tb_spad_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam int BW        = 32;
    localparam int OFFSET_SZ = 12;
    localparam int MAX_HOLD  = 4;
    localparam int RD_LAT    = 1;

    logic clk_ctrl = 1'b0;
    always #5 clk_ctrl = ~clk_ctrl;
    logic clk_ctrl_rst_low;

    // Request drive, index 0 = A, 1 = B.
    logic        v [2];
    logic        l [2];
    logic        w [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];

    logic        a_ready, a_rvalid, b_ready, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout = '0;
    logic [15:0] stall_cnt;

    spad_port_arbiter #(
        .ADDR_W(ADDR_W), .BW(BW), .OFFSET_SZ(OFFSET_SZ),
        .MAX_HOLD(MAX_HOLD), .RD_LAT(RD_LAT)
    ) dut (
        .clk_ctrl(clk_ctrl), .clk_ctrl_rst_low(clk_ctrl_rst_low),
        .a_valid(v[0]), .a_lock(l[0]), .a_addr(ad[0]), .a_wdata(wd[0]), .a_wstrb(w[0]),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(v[1]), .b_lock(l[1]), .b_addr(ad[1]), .b_wdata(wd[1]), .b_wstrb(w[1]),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .stall_cnt(stall_cnt)
    );

    // Single-port SRAM with one cycle read latency.
    logic [31:0] sram [4096];
    always @(posedge clk_ctrl) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr[11:0]] <= mem_din;
            else        mem_dout <= sram[mem_addr[11:0]];
        end
    end

    int n_checks;
    int n_errors;
    int cyc;

    // Reference model: port owner (-1 when free), round-robin priority,
    // hold age, stall total, expected memory and pending read returns.
    typedef struct {
        int          due;
        int          own;
        logic [31:0] data;
    } exp_rd_t;

    int          m_owner;
    int          m_prio;
    int          m_hold;
    int          m_stall;
    logic [31:0] ref_mem [4096];
    exp_rd_t     rq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_prio  = 0;
        m_hold  = 0;
        m_stall = 0;
        rq.delete();
    endtask

    task automatic clear_req();
        for (int r = 0; r < 2; r++) begin
            v[r] = 1'b0; l[r] = 1'b0; w[r] = 1'b0; ad[r] = '0; wd[r] = '0;
        end
    endtask

    // One clock cycle with the currently driven requests: predict, compare at
    // the falling edge, advance the model, then cross the rising edge.
    task automatic step(input bit rst_at_edge);
        int          win;
        int          oth;
        bit          forced;
        int          idx;
        logic        e_we;
        logic [31:0] e_addr, e_din;
        logic        e_rv [2];
        logic [31:0] e_rd [2];

        @(negedge clk_ctrl);
        win    = -1;
        forced = 1'b0;
        if (m_owner < 0) begin
            if (v[0] && v[1]) win = m_prio;
            else if (v[0])    win = 0;
            else if (v[1])    win = 1;
        end else begin
            oth = 1 - m_owner;
            if (m_hold == MAX_HOLD && v[oth]) begin
                win    = oth;
                forced = 1'b1;
            end else if (v[m_owner]) begin
                win = m_owner;
            end
        end

        e_we = 1'b0; e_addr = '0; e_din = '0;
        if (win >= 0) begin
            e_we   = w[win];
            e_addr = {20'h0, ad[win][11:0]};
            e_din  = wd[win];
        end
        e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rv[rq[0].own] = 1'b1;
            e_rd[rq[0].own] = rq[0].data;
            void'(rq.pop_front());
        end

        check("a_ready",   32'(a_ready),   32'(win == 0));
        check("b_ready",   32'(b_ready),   32'(win == 1));
        check("mem_en",    32'(mem_en),    32'(win >= 0));
        check("mem_we",    32'(mem_we),    32'(e_we));
        check("mem_addr",  mem_addr,       e_addr);
        check("mem_din",   mem_din,        e_din);
        check("a_rvalid",  32'(a_rvalid),  32'(e_rv[0]));
        check("a_rdata",   a_rdata,        e_rd[0]);
        check("b_rvalid",  32'(b_rvalid),  32'(e_rv[1]));
        check("b_rdata",   b_rdata,        e_rd[1]);
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));

        m_stall = m_stall + int'(v[0] && win != 0) + int'(v[1] && win != 1);
        if (m_stall > 65535) m_stall = 65535;

        if (win >= 0) begin
            idx = int'(ad[win][11:0]);
            if (w[win]) ref_mem[idx] = wd[win];
            else        rq.push_back('{cyc + RD_LAT, win, ref_mem[idx]});
        end

        if (m_owner < 0) begin
            if (win >= 0) begin
                if (l[win]) begin m_owner = win; m_hold = 1; end
                else        m_prio = 1 - win;
            end
        end else if (forced) begin
            m_prio = m_owner;
            if (l[win]) begin m_owner = win; m_hold = 1; end
            else        m_owner = -1;
        end else begin
            if (m_hold < MAX_HOLD) m_hold++;
            if (win == m_owner && !l[win]) begin
                m_owner = -1;
                m_prio  = 1 - win;
            end
        end

        @(posedge clk_ctrl);
        if (rst_at_edge) begin
            clk_ctrl_rst_low = 1'b0;
            model_reset();
        end else begin
            #1;
        end
        cyc++;
    endtask

    // Hold reset for two cycles with both requesters pushing; every output
    // must stay at 0 regardless.
    task automatic apply_reset();
        clk_ctrl_rst_low = 1'b0;
        model_reset();
        for (int r = 0; r < 2; r++) begin
            v[r] = 1'b1; l[r] = 1'b1; w[r] = 1'b1; ad[r] = 32'h0000_0010; wd[r] = '1;
        end
        repeat (2) begin
            @(negedge clk_ctrl);
            check("rst_a_ready",  32'(a_ready),  32'h0);
            check("rst_b_ready",  32'(b_ready),  32'h0);
            check("rst_a_rvalid", 32'(a_rvalid), 32'h0);
            check("rst_b_rvalid", 32'(b_rvalid), 32'h0);
            check("rst_a_rdata",  a_rdata,       32'h0);
            check("rst_b_rdata",  b_rdata,       32'h0);
            check("rst_mem_en",   32'(mem_en),   32'h0);
            check("rst_mem_we",   32'(mem_we),   32'h0);
            check("rst_mem_addr", mem_addr,      32'h0);
            check("rst_mem_din",  mem_din,       32'h0);
            check("rst_stall",    32'(stall_cnt), 32'h0);
        end
        clear_req();
        @(negedge clk_ctrl);
        clk_ctrl_rst_low = 1'b1;
        @(posedge clk_ctrl);
        #1;
    endtask

    task automatic write_b(input logic [31:0] addr, input logic [31:0] data);
        clear_req();
        v[1] = 1'b1; w[1] = 1'b1; ad[1] = addr; wd[1] = data;
        step(1'b0);
        clear_req();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        clk_ctrl_rst_low = 1'b0;
        clear_req();
        model_reset();
        apply_reset();

        write_b(32'h0000_0010, 32'hDEAD_BEEF);
        write_b(32'h0000_0020, 32'hCAFE_F00D);
        write_b(32'h0000_0123, 32'h5A5A_0123);
        apply_reset();

        // Contention straight out of reset: A first, B next, data in order.
        v[0] = 1'b1; ad[0] = 32'h0000_0010;
        v[1] = 1'b1; ad[1] = 32'h0000_0020;
        step(1'b0);
        check("t1_a_rvalid", 32'(a_rvalid), 32'h1);
        check("t1_a_rdata",  a_rdata,       32'hDEAD_BEEF);
        v[0] = 1'b0;
        #1;
        check("t1_b_ready", 32'(b_ready), 32'h1);
        step(1'b0);
        check("t1_b_rvalid", 32'(b_rvalid), 32'h1);
        check("t1_b_rdata",  b_rdata,       32'hCAFE_F00D);
        clear_req();
        step(1'b0);

        // Locked 4-beat write burst from A holds B off.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            v[0] = 1'b1; w[0] = 1'b1; l[0] = (k < 3);
            ad[0] = 32'h0000_0100 + 32'(4 * k); wd[0] = 32'hA000_0000 + 32'(k);
            v[1] = 1'b1; ad[1] = 32'h0000_0020;
            #1;
            check("t2_b_held", 32'(b_ready), 32'h0);
            step(1'b0);
        end
        v[0] = 1'b0;
        #1;
        check("t2_b_ready", 32'(b_ready),   32'h1);
        check("t2_stall",   32'(stall_cnt), 32'd4);
        step(1'b0);
        clear_req();
        step(1'b0);

        // Owner locks then goes quiet; B only gets in once the hold expires.
        apply_reset();
        v[0] = 1'b1; l[0] = 1'b1; ad[0] = 32'h0000_0010;
        step(1'b0);
        clear_req();
        v[1] = 1'b1; ad[1] = 32'h0000_0020;
        for (int k = 1; k < 4; k++) begin
            #1;
            check("t3_no_grant", 32'(a_ready | b_ready), 32'h0);
            step(1'b0);
        end
        #1;
        check("t3_b_forced", 32'(b_ready), 32'h1);
        step(1'b0);
        v[0] = 1'b1; ad[0] = 32'h0000_0010;
        #1;
        check("t3_prio_a", 32'(a_ready), 32'h1);
        step(1'b0);
        clear_req();
        step(1'b0);

        // Upper address bits are masked off.
        v[0] = 1'b1; ad[0] = 32'hFFFF_F123;
        #1;
        check("t4_mem_addr", mem_addr,      32'h0000_0123);
        check("t4_mem_we",   32'(mem_we),   32'h0);
        step(1'b0);
        clear_req();

        // Write then read-back by B; only the read returns data.
        write_b(32'h0000_0040, 32'h1234_5678);
        check("t5_wr_no_rvalid", 32'(b_rvalid), 32'h0);
        v[1] = 1'b1; ad[1] = 32'h0000_0040;
        step(1'b0);
        check("t5_b_rvalid", 32'(b_rvalid), 32'h1);
        check("t5_b_rdata",  b_rdata,       32'h1234_5678);
        clear_req();
        step(1'b0);

        // Reset right behind an accepted read drops its return.
        v[0] = 1'b1; ad[0] = 32'h0000_0010;
        step(1'b1);
        apply_reset();
        check("t6_a_rvalid", 32'(a_rvalid), 32'h0);
        check("t6_b_rvalid", 32'(b_rvalid), 32'h0);
        v[0] = 1'b1; ad[0] = 32'h0000_0020;
        v[1] = 1'b1; ad[1] = 32'h0000_0010;
        #1;
        check("t6_a_wins", 32'(a_ready), 32'h1);
        step(1'b0);
        clear_req();
        step(1'b0);

        // Randomized traffic over a small address window.
        for (int k = 0; k < 16; k++) write_b(32'(4 * k), $urandom());
        for (int i = 0; i < 1500; i++) begin
            for (int r = 0; r < 2; r++) begin
                v[r]  = ($urandom_range(0, 9) < 7);
                l[r]  = ($urandom_range(0, 9) < 3);
                w[r]  = 1'($urandom_range(0, 1));
                ad[r] = $urandom();
                ad[r][11:0] = 12'(4 * $urandom_range(0, 15));
                wd[r] = $urandom();
            end
            step(1'b0);
        end
        clear_req();
        repeat (4) step(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
